// File: rtl/dsp_mac_sequencer_if.sv
// dsp_mac_sequencer_if: job/beat handshake and slice control bundle between feeder and MAC sequencer
interface dsp_mac_sequencer_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic             CEAB;
    logic [7:0]       OPMODE;
    logic             res_valid;
    modport master (output start, len, in_valid, input busy, in_ready, CEAB, OPMODE, res_valid);
    modport slave  (input start, len, in_valid, output busy, in_ready, CEAB, OPMODE, res_valid);
endinterface

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: drives a DSP48A1-style slice through one N-term multiply-accumulate job
module dsp_mac_sequencer #(
    parameter int LEN_W    = 8,
    parameter int OPM_DLY  = 1,
    parameter int PIPE_LAT = 3
) (
    input  logic                CLK,
    input  logic                RST,
    dsp_mac_sequencer_if.slave  bus
);
    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_ACC   = 8'h09;
    localparam logic [7:0] OPM_HOLD  = 8'h08;
    localparam logic [7:0] OPM_CLR   = 8'h00;
    localparam logic [3:0] DRAIN_LD  = 4'(PIPE_LAT - 1);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
    // with a one-cycle pipeline the cycle after the last beat is already the result cycle
    localparam state_t END_ST = (PIPE_LAT == 1) ? DONE : DRAIN;
    state_t           state, state_nx;
    logic [LEN_W-1:0] left, left_nx;
    logic             first, first_nx;
    logic [3:0]       dcnt, dcnt_nx;
    logic [7:0]       push;
    logic             beat;
    // state, remaining-term and drain counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            left  <= '0;
            first <= 1'b0;
            dcnt  <= '0;
        end else begin
            state <= state_nx;
            left  <= left_nx;
            first <= first_nx;
            dcnt  <= dcnt_nx;
        end
    end
    // next state and the opcode pushed into the delay line this cycle
    always_comb begin
        state_nx = state;
        left_nx  = left;
        first_nx = first;
        dcnt_nx  = dcnt;
        push     = OPM_HOLD;
        beat     = bus.in_valid && state == ACCUM && !RST;
        case (state)
            IDLE: if (bus.start) begin
                if (bus.len != '0) begin
                    left_nx  = bus.len;
                    first_nx = 1'b1;
                    state_nx = ACCUM;
                end else begin
                    push     = OPM_CLR;
                    dcnt_nx  = DRAIN_LD;
                    state_nx = END_ST;
                end
            end
            ACCUM: if (beat) begin
                push     = first ? OPM_FIRST : OPM_ACC;
                first_nx = 1'b0;
                left_nx  = left - LEN_W'(1);
                if (left == LEN_W'(1)) begin
                    dcnt_nx  = DRAIN_LD;
                    state_nx = END_ST;
                end
            end
            DRAIN: if (dcnt <= 4'd1) state_nx = DONE; else dcnt_nx = dcnt - 4'd1;
            DONE:  state_nx = IDLE;
        endcase
        if (RST) push = OPM_HOLD;
    end
    assign bus.busy      = state != IDLE && !RST;
    assign bus.in_ready  = state == ACCUM && !RST;
    assign bus.CEAB      = beat;
    assign bus.res_valid = state == DONE && !RST;
    generate
        if (OPM_DLY == 0) begin : g_comb
            assign bus.OPMODE = push;
        end else begin : g_dly
            logic [7:0] dl [OPM_DLY];
            // opcode delay line aligning each opcode with its product at the post-adder
            always_ff @(posedge CLK) begin
                if (RST) begin
                    for (int i = 0; i < OPM_DLY; i++) dl[i] <= OPM_HOLD;
                end else begin
                    dl[0] <= push;
                    for (int i = 1; i < OPM_DLY; i++) dl[i] <= dl[i-1];
                end
            end
            assign bus.OPMODE = dl[OPM_DLY-1];
        end
    endgenerate
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: directed vector table plus hand sequences for reset, start/reset collision and max length
module tb_dsp_mac_sequencer;
    logic CLK;
    logic RST;
    int   n_cmp;
    int   n_bad;
    dsp_mac_sequencer_if #(.LEN_W(8)) a ();
    dsp_mac_sequencer_if #(.LEN_W(4)) b ();
    dsp_mac_sequencer #(.LEN_W(8), .OPM_DLY(1), .PIPE_LAT(3)) dut (.CLK(CLK), .RST(RST), .bus(a));
    dsp_mac_sequencer #(.LEN_W(4), .OPM_DLY(1), .PIPE_LAT(3)) dut_max (.CLK(CLK), .RST(RST), .bus(b));
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    typedef struct {
        logic       st;
        logic [7:0] ln;
        logic       iv;
        logic       bz;
        logic       rd;
        logic       ce;
        logic [7:0] op;
        logic       rv;
    } vec_t;
    vec_t vec[$];
    task automatic add(input logic st, input logic [7:0] ln, input logic iv, input logic bz,
                       input logic rd, input logic ce, input logic [7:0] op, input logic rv);
        vec_t v;
        v = '{st, ln, iv, bz, rd, ce, op, rv};
        vec.push_back(v);
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    initial begin
        int beats, nf, na, nrv, rvc, last;
        n_cmp = 0;
        n_bad = 0;
        RST = 1'b1;
        a.start = 1'b0; a.len = '0; a.in_valid = 1'b0;
        b.start = 1'b0; b.len = '0; b.in_valid = 1'b0;
        // basic job
        add(1,3,0, 0,0,0,8'h08,0); add(0,3,1, 1,1,1,8'h08,0); add(0,3,1, 1,1,1,8'h01,0);
        add(0,3,1, 1,1,1,8'h09,0); add(0,3,1, 1,0,0,8'h09,0); add(0,3,1, 1,0,0,8'h08,0);
        add(0,3,1, 1,0,0,8'h08,1); add(0,3,0, 0,0,0,8'h08,0);
        // gapped input 1,0,0,1,0,1
        add(1,3,0, 0,0,0,8'h08,0); add(0,3,1, 1,1,1,8'h08,0); add(0,3,0, 1,1,0,8'h01,0);
        add(0,3,0, 1,1,0,8'h08,0); add(0,3,1, 1,1,1,8'h08,0); add(0,3,0, 1,1,0,8'h09,0);
        add(0,3,1, 1,1,1,8'h08,0); add(0,3,1, 1,0,0,8'h09,0); add(0,3,0, 1,0,0,8'h08,0);
        add(0,3,0, 1,0,0,8'h08,1); add(0,3,0, 0,0,0,8'h08,0);
        // zero length
        add(1,0,0, 0,0,0,8'h08,0); add(0,0,1, 1,0,0,8'h00,0); add(0,0,1, 1,0,0,8'h08,0);
        add(0,0,0, 1,0,0,8'h08,1); add(0,0,0, 0,0,0,8'h08,0);
        // start (len=5) while busy is ignored
        add(1,3,0, 0,0,0,8'h08,0); add(1,5,1, 1,1,1,8'h08,0); add(1,5,1, 1,1,1,8'h01,0);
        add(1,5,1, 1,1,1,8'h09,0); add(1,5,1, 1,0,0,8'h09,0); add(1,5,1, 1,0,0,8'h08,0);
        add(1,5,0, 1,0,0,8'h08,1); add(0,5,0, 0,0,0,8'h08,0); add(0,5,0, 0,0,0,8'h08,0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_busy", a.busy, 0);
        chk("rst_ready", a.in_ready, 0);
        chk("rst_ceab", a.CEAB, 0);
        chk("rst_rv", a.res_valid, 0);
        chk("rst_opm", a.OPMODE, 8'h08);
        chk("rst_opm_max", b.OPMODE, 8'h08);
        @(posedge CLK); #1 RST = 1'b0;
        foreach (vec[i]) begin
            @(posedge CLK); #1;
            a.start = vec[i].st; a.len = vec[i].ln; a.in_valid = vec[i].iv;
            @(negedge CLK);
            chk($sformatf("v%0d_busy", i), a.busy, vec[i].bz);
            chk($sformatf("v%0d_ready", i), a.in_ready, vec[i].rd);
            chk($sformatf("v%0d_ceab", i), a.CEAB, vec[i].ce);
            chk($sformatf("v%0d_opm", i), a.OPMODE, vec[i].op);
            chk($sformatf("v%0d_rv", i), a.res_valid, vec[i].rv);
        end
        // start and reset in the same cycle: reset wins
        @(posedge CLK); #1 RST = 1'b1; a.start = 1'b1; a.len = 8'd3; a.in_valid = 1'b0;
        @(negedge CLK);
        chk("sr_busy_in", a.busy, 0);
        @(posedge CLK); #1 RST = 1'b0; a.start = 1'b0;
        @(negedge CLK);
        chk("sr_busy", a.busy, 0);
        chk("sr_ready", a.in_ready, 0);
        // reset after the second beat of a len=4 job
        @(posedge CLK); #1 a.start = 1'b1; a.len = 8'd4;
        @(posedge CLK); #1 a.start = 1'b0; a.in_valid = 1'b1;
        @(negedge CLK); chk("rm_beat1", a.CEAB, 1);
        @(posedge CLK); #1;
        @(negedge CLK); chk("rm_beat2", a.CEAB, 1);
        @(posedge CLK); #1 RST = 1'b1;
        @(negedge CLK); chk("rm_ceab_in_rst", a.CEAB, 0);
        @(posedge CLK); #1 RST = 1'b0; a.in_valid = 1'b0;
        @(negedge CLK);
        chk("rm_busy", a.busy, 0);
        chk("rm_ready", a.in_ready, 0);
        chk("rm_opm", a.OPMODE, 8'h08);
        nrv = 0;
        repeat (10) begin
            @(negedge CLK);
            if (a.res_valid) nrv++;
        end
        chk("rm_no_rv", nrv, 0);
        // fresh len=2 job after reset
        @(posedge CLK); #1 a.start = 1'b1; a.len = 8'd2;
        beats = 0; nf = 0; na = 0; nrv = 0; rvc = -1; last = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge CLK); #1 a.start = 1'b0; a.in_valid = 1'b1;
            @(negedge CLK);
            if (a.CEAB) begin beats++; last = c; end
            if (a.OPMODE == 8'h01) nf++;
            if (a.OPMODE == 8'h09) na++;
            if (a.res_valid) begin nrv++; rvc = c; end
        end
        a.in_valid = 1'b0;
        chk("j2_beats", beats, 2);
        chk("j2_first", nf, 1);
        chk("j2_acc", na, 1);
        chk("j2_rv_cnt", nrv, 1);
        chk("j2_rv_cycle", rvc, 5);
        chk("j2_last", last, 2);
        // max length on the 4-bit instance
        @(posedge CLK); #1 b.start = 1'b1; b.len = 4'd15;
        beats = 0; nf = 0; na = 0; nrv = 0; rvc = -1; last = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge CLK); #1 b.start = 1'b0; b.in_valid = 1'b1;
            @(negedge CLK);
            if (b.CEAB) begin beats++; last = c; end
            if (b.OPMODE == 8'h01) nf++;
            if (b.OPMODE == 8'h09) na++;
            if (b.res_valid) begin nrv++; rvc = c; end
        end
        chk("max_beats", beats, 15);
        chk("max_first", nf, 1);
        chk("max_acc", na, 14);
        chk("max_rv_cnt", nrv, 1);
        chk("max_rv_cycle", rvc, 18);
        chk("max_busy_end", b.busy, 0);
        chk("max_opm_end", b.OPMODE, 8'h08);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
